// File: rtl/drp_pkg.sv
// Shared definitions for the DRP responder model: FSM state encoding, the
// DRP data width, and the location of the two speed-select bits in the
// transceiver register map.
package drp_pkg;

    localparam int DRP_DATA_W = 16;

    // Speed-select bits: reg[0x46][2] and reg[0x45][15]
    localparam logic [6:0] DRP_ADDR_RATE0 = 7'h46;
    localparam logic [6:0] DRP_ADDR_RATE1 = 7'h45;
    localparam int         RATE0_BIT      = 2;
    localparam int         RATE1_BIT      = 15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } drp_state_e;

endpackage

// File: rtl/drp_lock_model.sv
// PLL lock model: gtp_lock rises LOCK_DLY cycles after mgt_reset is seen low.
// The counter clears while mgt_reset is high and saturates at LOCK_DLY.
//   clk, reset : system clock, synchronous active-high reset
//   mgt_reset  : transceiver reset from the initiator
//   gtp_lock   : modelled lock indication
module drp_lock_model #(
    parameter int LOCK_DLY = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic mgt_reset,
    output logic gtp_lock
);

    localparam logic [15:0] LOCK_TC = 16'(LOCK_DLY);

    logic [15:0] lock_cnt_q, lock_cnt_d;

    always_comb begin
        lock_cnt_d = lock_cnt_q;
        if (mgt_reset) begin
            lock_cnt_d = '0;
        end else if (lock_cnt_q != LOCK_TC) begin
            lock_cnt_d = lock_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_q <= '0;
        end else begin
            lock_cnt_q <= lock_cnt_d;
        end
    end

    // Lock drops immediately with mgt_reset rather than one cycle later
    assign gtp_lock = !mgt_reset && (lock_cnt_q == LOCK_TC);

endmodule

// File: rtl/drp_responder_model.sv
// DRP responder (slave) model: a DEPTH x 16 register array answered over
// daddr/den/dwe/di with dout/drdy after LATENCY cycles. It decodes the
// speed-select bits into cfg_gen1/cfg_gen2/cfg_mixed and models PLL lock.
//   clk, reset          : system clock, synchronous active-high reset
//   daddr/den/dwe/di    : DRP request
//   dout/drdy           : DRP response (drdy is a one-cycle strobe)
//   mgt_reset/gtp_lock  : transceiver reset in, modelled lock out
//   cfg_gen1/2/mixed    : link-rate decode of reg[0x46][2] and reg[0x45][15]
// Optional: define DRP_PROTOCOL_CHECK_EN to add drp_err (sticky) and
// err_cnt (saturating) which flag illegal DRP traffic.
//
// state | meaning
// IDLE  | waiting for den; request fields latched on acceptance
// BUSY  | latency countdown, den ignored
// RESP  | drdy high for this cycle, den ignored
module drp_responder_model
    import drp_pkg::*;
#(
    parameter int                    ADDR_W   = 7,
    parameter int                    DEPTH    = 128,
    parameter int                    LATENCY  = 3,
    parameter logic [DRP_DATA_W-1:0] RST_45   = 16'h8000,
    parameter logic [DRP_DATA_W-1:0] RST_46   = 16'h0004,
    parameter int                    LOCK_DLY = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     daddr,
    input  logic                  den,
    input  logic                  dwe,
    input  logic [DRP_DATA_W-1:0] di,
    output logic [DRP_DATA_W-1:0] dout,
    output logic                  drdy,
    input  logic                  mgt_reset,
    output logic                  gtp_lock,
    output logic                  cfg_gen2,
    output logic                  cfg_gen1,
    output logic                  cfg_mixed
`ifdef DRP_PROTOCOL_CHECK_EN
    ,
    output logic                  drp_err,
    output logic [7:0]            err_cnt
`endif
);

    localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    drp_state_e            state_q, state_d;
    logic [3:0]            lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DRP_DATA_W-1:0] wdata_q, wdata_d;
    logic [DRP_DATA_W-1:0] dout_q, dout_d;
    logic [DRP_DATA_W-1:0] regs_q [DEPTH];
    logic [DRP_DATA_W-1:0] regs_d [DEPTH];
    logic                  enter_resp;
    logic                  req_mapped;
    logic [IDX_W-1:0]      req_idx;
    logic                  rate0_bit, rate1_bit;

    always_comb begin
        state_d    = state_q;
        lat_cnt_d  = lat_cnt_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        enter_resp = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (den) begin
                    addr_d    = daddr;
                    we_d      = dwe;
                    wdata_d   = di;
                    lat_cnt_d = LAT_LOAD;
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                lat_cnt_d = lat_cnt_q - 4'd1;
                if (lat_cnt_d == 4'd0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Commit uses the _d request fields so LATENCY==1 (enter RESP straight
    // from IDLE) sees the request being accepted on this edge.
    assign req_mapped = (32'(addr_d) < 32'(DEPTH));
    assign req_idx    = IDX_W'(addr_d);

    always_comb begin
        regs_d = regs_q;
        dout_d = dout_q;
        if (enter_resp) begin
            if (we_d) begin
                dout_d = '0;
                if (req_mapped) begin
                    regs_d[req_idx] = wdata_d;
                end
            end else begin
                dout_d = req_mapped ? regs_q[req_idx] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            dout_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                if (i == int'(DRP_ADDR_RATE1)) begin
                    regs_q[i] <= RST_45;
                end else if (i == int'(DRP_ADDR_RATE0)) begin
                    regs_q[i] <= RST_46;
                end else begin
                    regs_q[i] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            dout_q    <= dout_d;
            regs_q    <= regs_d;
        end
    end

    assign drdy = (state_q == RESP);
    assign dout = dout_q;

    // With a shallow array the rate registers do not exist; the decode then
    // sees their reset values permanently.
    if (int'(DRP_ADDR_RATE0) < DEPTH) begin : g_rate0_reg
        assign rate0_bit = regs_q[IDX_W'(DRP_ADDR_RATE0)][RATE0_BIT];
    end else begin : g_rate0_const
        assign rate0_bit = RST_46[RATE0_BIT];
    end

    if (int'(DRP_ADDR_RATE1) < DEPTH) begin : g_rate1_reg
        assign rate1_bit = regs_q[IDX_W'(DRP_ADDR_RATE1)][RATE1_BIT];
    end else begin : g_rate1_const
        assign rate1_bit = RST_45[RATE1_BIT];
    end

    assign cfg_gen2  = !rate0_bit && !rate1_bit;
    assign cfg_gen1  = rate0_bit && rate1_bit;
    assign cfg_mixed = !(cfg_gen1 || cfg_gen2);

    drp_lock_model #(
        .LOCK_DLY(LOCK_DLY)
    ) u_lock (
        .clk      (clk),
        .reset    (reset),
        .mgt_reset(mgt_reset),
        .gtp_lock (gtp_lock)
    );

`ifdef DRP_PROTOCOL_CHECK_EN
    logic       drp_err_q, drp_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic       err_ev;

    // The three events are mutually exclusive in a cycle (den high vs low,
    // IDLE vs BUSY), so one increment per cycle is enough.
    always_comb begin
        err_ev = 1'b0;
        if (den && (state_q == BUSY) && ((daddr != addr_q) || (dwe != we_q))) begin
            err_ev = 1'b1;
        end
        if (den && (state_q == IDLE) && !(32'(daddr) < 32'(DEPTH))) begin
            err_ev = 1'b1;
        end
        if (dwe && !den) begin
            err_ev = 1'b1;
        end
        drp_err_d = drp_err_q || err_ev;
        err_cnt_d = err_cnt_q;
        if (err_ev && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            drp_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            drp_err_q <= drp_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign drp_err = drp_err_q;
    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_drp_responder_model.sv
// Bench for drp_responder_model: a default-depth instance and a DEPTH=64
// instance (for unmapped addresses) share clk/reset. Expected read data comes
// from a register mirror, is queued when a request is driven and popped when
// drdy appears.
module tb_drp_responder_model;

    localparam int LATENCY  = 3;
    localparam int LOCK_DLY = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  daddr;
    logic        den, dwe;
    logic [15:0] di;
    logic [15:0] dout;
    logic        drdy;
    logic        mgt_reset;
    logic        gtp_lock, cfg_gen2, cfg_gen1, cfg_mixed;

    logic [6:0]  s_daddr;
    logic        s_den, s_dwe;
    logic [15:0] s_di;
    logic [15:0] s_dout;
    logic        s_drdy;
    logic        s_mgt_reset;
    logic        s_gtp_lock, s_cfg_gen2, s_cfg_gen1, s_cfg_mixed;

`ifdef DRP_PROTOCOL_CHECK_EN
    logic        drp_err, s_drp_err;
    logic [7:0]  err_cnt, s_err_cnt;
`endif

    always #5 clk = ~clk;

    drp_responder_model u_dut (
        .clk(clk), .reset(reset), .daddr(daddr), .den(den), .dwe(dwe), .di(di),
        .dout(dout), .drdy(drdy), .mgt_reset(mgt_reset), .gtp_lock(gtp_lock),
        .cfg_gen2(cfg_gen2), .cfg_gen1(cfg_gen1), .cfg_mixed(cfg_mixed)
`ifdef DRP_PROTOCOL_CHECK_EN
        , .drp_err(drp_err), .err_cnt(err_cnt)
`endif
    );

    drp_responder_model #(.DEPTH(64)) u_dut64 (
        .clk(clk), .reset(reset), .daddr(s_daddr), .den(s_den), .dwe(s_dwe), .di(s_di),
        .dout(s_dout), .drdy(s_drdy), .mgt_reset(s_mgt_reset), .gtp_lock(s_gtp_lock),
        .cfg_gen2(s_cfg_gen2), .cfg_gen1(s_cfg_gen1), .cfg_mixed(s_cfg_mixed)
`ifdef DRP_PROTOCOL_CHECK_EN
        , .drp_err(s_drp_err), .err_cnt(s_err_cnt)
`endif
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] m_main [128];
    logic [15:0] m_64   [64];
    logic [15:0] sb_q   [$];
    bit          sel64  = 1'b0;
    logic        obs_drdy;
    logic [15:0] obs_dout;

    assign obs_drdy = sel64 ? s_drdy : drdy;
    assign obs_dout = sel64 ? s_dout : dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mirror_reset();
        for (int i = 0; i < 128; i++) m_main[i] = 16'h0000;
        m_main[7'h45] = 16'h8000;
        m_main[7'h46] = 16'h0004;
        for (int i = 0; i < 64; i++) m_64[i] = 16'h0000;
    endtask

    task automatic drop_req();
        den = 1'b0; dwe = 1'b0; s_den = 1'b0; s_dwe = 1'b0;
    endtask

    // Called at #1 after an edge; the request is accepted on the next edge.
    task automatic drp_access(input bit on64, input logic [6:0] addr, input bit we,
                              input logic [15:0] data, input bit hold);
        logic [15:0] exp_v;
        bit          got;
        bit          extra;
        sel64 = on64;
        if (on64) begin
            exp_v = (!we && addr < 7'd64) ? m_64[addr[5:0]] : 16'h0000;
            if (we && addr < 7'd64) m_64[addr[5:0]] = data;
            s_daddr = addr; s_dwe = we; s_di = data; s_den = 1'b1;
        end else begin
            exp_v = we ? 16'h0000 : m_main[addr];
            if (we) m_main[addr] = data;
            daddr = addr; dwe = we; di = data; den = 1'b1;
        end
        sb_q.push_back(exp_v);
        step();
        if (!hold) drop_req();
        got = 1'b0;
        for (int k = 0; k < LATENCY + 4 && !got; k++) begin
            if (obs_drdy) begin
                got = 1'b1;
                chk("drdy_latency", k, LATENCY - 1);
                chk("dout", obs_dout, sb_q.pop_front());
            end else begin
                step();
            end
        end
        if (!got) begin
            chk("drdy_timeout", obs_drdy, 1);
            sb_q.delete();
        end
        step();
        chk("drdy_width", obs_drdy, 0);
        drop_req();
        extra = 1'b0;
        repeat (LATENCY + 2) begin
            step();
            extra |= obs_drdy;
        end
        chk("no_retrigger", extra, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0]  ra;
        logic [15:0] rd;
        bit          seen;
        reset = 1'b1; mgt_reset = 1'b0; s_mgt_reset = 1'b0;
        daddr = '0; di = '0; s_daddr = '0; s_di = '0;
        drop_req();
        mirror_reset();
        repeat (3) step();
        chk("rst_drdy", drdy, 0);
        chk("rst_dout", dout, 0);
        chk("rst_lock", gtp_lock, 0);
        chk("rst_gen1", cfg_gen1, 1);
        chk("rst_gen2", cfg_gen2, 0);
        chk("rst_mixed", cfg_mixed, 0);
        chk("rst_gen1_d64", s_cfg_gen1, 1);

        // Lock counts from reset release as if mgt_reset had just fallen
        reset = 1'b0;
        for (int k = 1; k <= LOCK_DLY; k++) begin
            step();
            if (k == LOCK_DLY - 1) chk("lock_rel_early", gtp_lock, 0);
        end
        chk("lock_rel", gtp_lock, 1);

        drp_access(1'b0, 7'h46, 1'b0, 16'h0000, 1'b0);
        chk("gen1_default", cfg_gen1, 1);
        drp_access(1'b0, 7'h46, 1'b1, 16'h0000, 1'b0);
        chk("mixed_between", cfg_mixed, 1);
        chk("gen1_between", cfg_gen1, 0);
        drp_access(1'b0, 7'h45, 1'b1, 16'h0000, 1'b0);
        chk("gen2_after", cfg_gen2, 1);
        chk("mixed_after", cfg_mixed, 0);
        drp_access(1'b0, 7'h45, 1'b0, 16'h0000, 1'b0);
        drp_access(1'b0, 7'h46, 1'b1, 16'h0004, 1'b0);
        chk("mixed_back", cfg_mixed, 1);

        for (int i = 0; i < 4; i++) begin
            ra = 7'($urandom_range(0, 63));
            rd = 16'($urandom);
            drp_access(1'b0, ra, 1'b1, rd, 1'b0);
            drp_access(1'b0, ra, 1'b0, 16'h0000, 1'b0);
        end

        // Initiator-style: den held through the drdy cycle
        drp_access(1'b0, 7'h46, 1'b0, 16'h0000, 1'b1);
        drp_access(1'b0, 7'h20, 1'b1, 16'h5A5A, 1'b1);
        drp_access(1'b0, 7'h20, 1'b0, 16'h0000, 1'b1);

        // mgt_reset pulse
        mgt_reset = 1'b1;
        #1;
        chk("lock_drop", gtp_lock, 0);
        repeat (16) begin
            step();
            chk("lock_pulse", gtp_lock, 0);
        end
        mgt_reset = 1'b0;
        for (int k = 1; k <= LOCK_DLY + 2; k++) begin
            step();
            chk("lock_count", gtp_lock, (k >= LOCK_DLY) ? 1 : 0);
        end

        // Reset during BUSY of a write: the committing edge sees reset
        sel64 = 1'b0;
        daddr = 7'h10; dwe = 1'b1; di = 16'hBEEF; den = 1'b1;
        step();
        drop_req();
        step();
        reset = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            step();
            seen |= drdy;
        end
        reset = 1'b0;
        mirror_reset();
        repeat (LATENCY + 2) begin
            step();
            seen |= drdy;
        end
        chk("midreset_no_drdy", seen, 0);
        chk("midreset_gen1", cfg_gen1, 1);
        drp_access(1'b0, 7'h10, 1'b0, 16'h0000, 1'b0);

`ifdef DRP_PROTOCOL_CHECK_EN
        chk("perr_clean", drp_err, 0);
        chk("perr_cnt_clean", err_cnt, 0);
        dwe = 1'b1;
        step();
        dwe = 1'b0;
        chk("perr_dwe", drp_err, 1);
        chk("perr_dwe_cnt", err_cnt, 1);
`endif

        // Shallow instance: unmapped reads return zero, unmapped writes drop
        drp_access(1'b1, 7'h05, 1'b1, 16'h1234, 1'b0);
        drp_access(1'b1, 7'h05, 1'b0, 16'h0000, 1'b0);
        drp_access(1'b1, 7'h7F, 1'b0, 16'h0000, 1'b0);
`ifdef DRP_PROTOCOL_CHECK_EN
        chk("d64_err", s_drp_err, 1);
        chk("d64_err_cnt", s_err_cnt, 1);
`endif
        drp_access(1'b1, 7'h46, 1'b1, 16'h0000, 1'b0);
        chk("d64_gen1_const", s_cfg_gen1, 1);
        drp_access(1'b1, 7'h05, 1'b0, 16'h0000, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
